r2sdf_bf_stage_16b: RTL
=======================

R2SDF_BF_STAGE_16B -- requirements
Module: r2sdf_bf_stage_16b

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the feedback delay length in samples (power of two, 1..32); the frame is 2*DEPTH samples.
REQ-002 The block SHALL have parameter CW, default $clog2(2*DEPTH), meaning the sample-counter width.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port RST  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port IN_VALID  input  1  the input sample is present this cycle.
REQ-006 The block SHALL have port REAL_IN  input  16  input real part, two's complement.
REQ-007 The block SHALL have port IMAG_IN  input  16  input imaginary part, two's complement.
REQ-008 The block SHALL have port OUT_VALID  output  1  the output sample is valid this cycle.
REQ-009 The block SHALL have port REAL_OUT  output  16  output real part, which feeds the downstream constant twiddle multiplier.
REQ-010 The block SHALL have port IMAG_OUT  output  16  output imaginary part.
REQ-011 The block SHALL have port OUT_IDX  output  CW  the position of the output sample within its frame, used downstream to select the twiddle constant.

Function
REQ-012 An input sample SHALL be accepted on every cycle with IN_VALID=1; there is no backpressure.
REQ-013 On a cycle with IN_VALID=0, the counter, delay line and state SHALL hold, and OUT_VALID SHALL be 0 on the next cycle.
REQ-014 Counter cnt SHALL increment on each accepted sample and wrap from 2*DEPTH-1 to 0.
REQ-015 The state machine SHALL have three states: FILL, BFLY and PASS.
REQ-016 Reset SHALL enter FILL.
REQ-017 The transition FILL->BFLY SHALL occur when the sample with cnt=DEPTH-1 is accepted.
REQ-018 The transition BFLY->PASS SHALL occur when the sample with cnt=2*DEPTH-1 is accepted.
REQ-019 The transition PASS->BFLY SHALL occur when the sample with cnt=DEPTH-1 is accepted.
REQ-020 In FILL, the input SHALL be pushed into the delay line and no output is produced.
REQ-021 In BFLY, with delay-line head d and input x: the output SHALL be (d+x)>>>1, and (d-x)>>>1 SHALL be pushed into the delay line.
REQ-022 In PASS, the output SHALL be the delay-line head d, and input x SHALL be pushed into the delay line.
REQ-023 Butterfly arithmetic SHALL be per component, 17-bit sign-extended add/subtract, then an arithmetic right shift by 1 truncated to 16 bits; overflow is therefore impossible and no saturation is needed.
REQ-024 The outputs SHALL be registered: OUT_VALID, REAL_OUT, IMAG_OUT and OUT_IDX SHALL update one cycle after the accepting IN_VALID cycle.
REQ-025 OUT_IDX SHALL be cnt-DEPTH in BFLY and cnt+DEPTH (mod 2*DEPTH) in PASS, so the sum half carries OUT_IDX 0..DEPTH-1 and the difference half carries DEPTH..2*DEPTH-1.
REQ-026 Differences of the last frame SHALL be emitted only when a following frame (or zero padding) is streamed in; the block has no internal flush.
REQ-027 When IN_VALID=0, the outputs SHALL keep their last values.

Reset
REQ-028 RST=1 SHALL asynchronously force the following reset values: state=FILL, cnt=0, OUT_VALID=0, REAL_OUT=0, IMAG_OUT=0, OUT_IDX=0.
REQ-029 Delay-line contents SHALL NOT be required to reset; they are overwritten during FILL before any use.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first sample after release SHALL be treated as cnt=0 in FILL.

Structure
REQ-031 Shared package fft_pkg SHALL hold the sample width (16), the FFT size (64) and the complex sample type (real and imaginary, 16 bits each).
REQ-032 The delay line SHALL be one sub-module, delay_line_32b: a DEPTH-entry shift register for a 32-bit {real,imag} word with an enable input and no reset.
REQ-033 The butterfly add/sub datapath SHALL stay inline in the block.

Verification
REQ-034 DEPTH=32, stream REAL_IN=n, IMAG_IN=0 for n=0..63, then 64 zeros -> the first 32 outputs are REAL_OUT=n+16, IMAG_OUT=0, OUT_IDX=n; the next 32 outputs are REAL_OUT=-16 (0xFFF0), OUT_IDX=32..63.
REQ-035 Extremes: d=0x7FFF, x=0x7FFF -> sum output 0x7FFF; d=0x8000, x=0x8000 -> sum output 0x8000; d=0x7FFF, x=0x8000 -> difference output 0x7FFF.
REQ-036 Insert IN_VALID=0 gaps of 1-5 cycles at random positions in the REQ-034 stream -> an identical output sequence and OUT_IDX sequence, with OUT_VALID low for exactly the gap cycles.
REQ-037 Assert RST for 1 cycle after 40 samples of a frame, then stream a fresh frame -> no OUT_VALID for the first 32 samples after release, then the REQ-034 values.
REQ-038 Continuous back-to-back frames with IMAG_IN=-n -> IMAG_OUT=-(n+16) in each sum half, with no bubble between frames.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, transform size, complex sample type,
// butterfly stage states and the halving add/sub used by every butterfly.
package fft_pkg;

  localparam int unsigned SampleW = 16;
  localparam int unsigned FftSize = 64;

  // {real, imag} packs into one 32-bit word, real in the upper half.
  typedef struct packed {
    logic [SampleW-1:0] re;
    logic [SampleW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    StFill,
    StBfly,
    StPass
  } bf_state_e;

  // One extra bit of headroom then halve, so the result always fits in SampleW bits.
  function automatic logic [SampleW-1:0] bf_half(input logic [SampleW-1:0] a,
                                                 input logic [SampleW-1:0] b,
                                                 input logic               sub);
    logic [SampleW:0] s;
    if (sub) s = {a[SampleW-1], a} - {b[SampleW-1], b};
    else     s = {a[SampleW-1], a} + {b[SampleW-1], b};
    return SampleW'(s >> 1);
  endfunction

endpackage

// File: rtl/delay_line_32b.sv
// DEPTH-entry shift register for a packed {real, imag} word. No reset: contents
// are always overwritten before they are read.
module delay_line_32b #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        CLK,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] mem_q [DEPTH];

  // Shift one place per enabled cycle; entry DEPTH-1 is the oldest word.
  always_ff @(posedge CLK) begin
    if (en) begin
      mem_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/r2sdf_bf_stage_16b.sv
// Radix-2 single-path delay-feedback butterfly stage. The first half of each
// frame fills the feedback delay, the second half emits halved sums and stores
// halved differences, which are emitted while the next frame fills.
module r2sdf_bf_stage_16b
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CW    = $clog2(2 * DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  input  logic [SampleW-1:0] REAL_IN,
  input  logic [SampleW-1:0] IMAG_IN,
  output logic               OUT_VALID,
  output logic [SampleW-1:0] REAL_OUT,
  output logic [SampleW-1:0] IMAG_OUT,
  output logic [CW-1:0]      OUT_IDX
);

  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [CW-1:0] CntHalf  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CntLast  = CW'(2 * DEPTH - 1);

  bf_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  cplx_t           head;
  cplx_t           push_data;
  logic [SampleW-1:0] sum_re, sum_im, dif_re, dif_im;

  delay_line_32b #(
    .DEPTH(DEPTH)
  ) u_delay (
    .CLK (CLK),
    .en  (IN_VALID),
    .din (push_data),
    .dout(head)
  );

  // Butterfly datapath: head is the sample from the first half, input from the second.
  always_comb begin
    sum_re = bf_half(head.re, REAL_IN, 1'b0);
    sum_im = bf_half(head.im, IMAG_IN, 1'b0);
    dif_re = bf_half(head.re, REAL_IN, 1'b1);
    dif_im = bf_half(head.im, IMAG_IN, 1'b1);
  end

  // Differences go back into the delay line during BFLY; raw input otherwise.
  always_comb begin
    push_data.re = REAL_IN;
    push_data.im = IMAG_IN;
    if (state_q == StBfly) begin
      push_data.re = dif_re;
      push_data.im = dif_im;
    end
  end

  // Frame sequencer with registered outputs; data outputs hold when nothing is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      OUT_VALID <= 1'b0;
      REAL_OUT  <= '0;
      IMAG_OUT  <= '0;
      OUT_IDX   <= '0;
    end else begin
      OUT_VALID <= 1'b0;
      if (IN_VALID) begin
        cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
        case (state_q)
          StFill: begin
            if (cnt_q == CntHalf) state_q <= StBfly;
          end
          StBfly: begin
            OUT_VALID <= 1'b1;
            REAL_OUT  <= sum_re;
            IMAG_OUT  <= sum_im;
            OUT_IDX   <= cnt_q - DepthC;
            if (cnt_q == CntLast) state_q <= StPass;
          end
          StPass: begin
            OUT_VALID <= 1'b1;
            REAL_OUT  <= head.re;
            IMAG_OUT  <= head.im;
            OUT_IDX   <= cnt_q + DepthC;
            if (cnt_q == CntHalf) state_q <= StBfly;
          end
          default: state_q <= StFill;
        endcase
      end
    end
  end

endmodule
